// File: rtl/pico_pkg.sv
// pico_pkg: shared types and widths for the configuration port serial paths
package pico_pkg;
  typedef enum logic {ADDR, DATA} poci_state_t;
  localparam int BYTE_W = 8;
  localparam int BIT_CNT_W = 3;
endpackage

// File: rtl/piso_shift_register.sv
// piso_shift_register: parallel load, shift left, serial MSB out
module piso_shift_register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         dout
);
  logic [W-1:0] r_sr;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_sr <= '0;
    else if (load) r_sr <= din;
    else if (shift) r_sr <= {r_sr[W-2:0], 1'b0};
  assign dout = r_sr[W-1];
endmodule

// File: rtl/poci_tx.sv
// poci_tx: decodes a read address from serial_in and streams auto-incrementing
// register bytes back on poci, MSB first
module poci_tx
  import pico_pkg::*;
#(
  parameter int DATA_W = BYTE_W
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              serial_in,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rd_addr,
  output logic              poci,
  output logic              poci_oe,
  output logic              byte_done
);
  poci_state_t          r_state, w_next;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [DATA_W-2:0]    r_addr_sr;
  logic [DATA_W-1:0]    r_rd_addr;
  logic                 r_byte_done;
  logic                 w_last, w_load, w_shift, w_tx_msb;
  always_comb begin
    w_last  = r_bit_cnt == '1;
    w_next  = (r_state == ADDR && w_last) ? DATA : r_state;
    w_load  = r_state == DATA && r_bit_cnt == '0;
    w_shift = r_state == DATA && !w_load;
  end
  always_ff @(posedge sclk or negedge rstn)
    if (!rstn) begin
      r_state     <= ADDR;
      r_bit_cnt   <= '0;
      r_addr_sr   <= '0;
      r_rd_addr   <= '0;
      r_byte_done <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_bit_cnt   <= r_bit_cnt + 1'b1;
      r_byte_done <= r_state == DATA && w_last;
      if (r_state == ADDR) r_addr_sr <= {r_addr_sr[DATA_W-3:0], serial_in};
      if (w_last) r_rd_addr <= (r_state == ADDR) ? {r_addr_sr, serial_in} : r_rd_addr + 1'b1;
    end
  // rd_data is captured once, at the end of bit 0; the MSB bypasses the register
  piso_shift_register #(.W(DATA_W)) u_tx_sr (
    .clk  (sclk),
    .rstn (rstn),
    .load (w_load),
    .shift(w_shift),
    .din  ({rd_data[DATA_W-2:0], 1'b0}),
    .dout (w_tx_msb)
  );
  assign rd_addr   = r_rd_addr;
  assign poci_oe   = r_state == DATA;
  assign poci      = poci_oe && (w_load ? rd_data[DATA_W-1] : w_tx_msb);
  assign byte_done = r_byte_done;
endmodule

// File: tb/tb_poci_tx.sv
// tb_poci_tx: frame-level reference model plus directed and random read frames
module tb_poci_tx;
  logic       sclk = 0, rstn = 0, serial_in = 0, clk_en = 0;
  logic [7:0] rd_data, rd_addr, d, a;
  logic       poci, poci_oe, byte_done;
  logic [7:0] mem [256];
  int         checks = 0, fails = 0;

  always #5 if (clk_en) sclk = ~sclk;
  assign rd_data = mem[rd_addr];

  poci_tx #(.DATA_W(8)) dut (
    .sclk(sclk), .rstn(rstn), .serial_in(serial_in), .rd_data(rd_data),
    .rd_addr(rd_addr), .poci(poci), .poci_oe(poci_oe), .byte_done(byte_done)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: n = posedges since frame start; bits 1..8 address, then 8-bit data slots
  int         n = 0, mb;
  logic [7:0] m_sr = 0, m_a = 0, m_snap = 0, ea;
  logic       ep, eoe, ebd;
  always @(negedge rstn) n = 0;
  always @(posedge sclk) begin
    if (rstn) begin
      if (n < 8) begin
        m_sr = {m_sr[6:0], serial_in};
        if (n == 7) m_a = m_sr;
      end else if ((n - 8) % 8 == 0) m_snap = mem[m_a + 8'((n - 8) / 8)];
      n++;
    end
    #2;
    if (n < 8) begin
      ea = 0; ep = 0; eoe = 0; ebd = 0;
    end else begin
      mb  = (n - 8) % 8;
      ea  = m_a + 8'((n - 8) / 8);
      eoe = 1;
      ep  = (mb == 0) ? mem[ea][7] : m_snap[7-mb];
      ebd = n >= 16 && mb == 0;
    end
    check("model_rd_addr", rd_addr, ea);
    check("model_poci", {7'b0, poci}, {7'b0, ep});
    check("model_poci_oe", {7'b0, poci_oe}, {7'b0, eoe});
    check("model_byte_done", {7'b0, byte_done}, {7'b0, ebd});
  end

  // All driver tasks start and end on a negedge
  task automatic send_addr(input logic [7:0] adr);
    for (int i = 7; i >= 0; i--) begin
      serial_in = adr[i];
      @(negedge sclk);
    end
  endtask

  task automatic read_byte(output logic [7:0] q, input int chg_bit, input logic [7:0] chg_addr,
                           input logic [7:0] chg_val);
    for (int i = 7; i >= 0; i--) begin
      q[i] = poci;
      if (7 - i == chg_bit) mem[chg_addr] = chg_val;
      serial_in = 1'($urandom);
      @(negedge sclk);
    end
  endtask

  task automatic do_reset;
    rstn = 0;
    @(negedge sclk);
    rstn = 1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    #3;
    check("reset_rd_addr", rd_addr, 8'h00);
    check("reset_poci", {7'b0, poci}, 8'h00);
    check("reset_oe", {7'b0, poci_oe}, 8'h00);
    check("reset_byte_done", {7'b0, byte_done}, 8'h00);
    rstn = 1;
    #3;
    check("idle_poci", {7'b0, poci}, 8'h00);
    check("idle_oe", {7'b0, poci_oe}, 8'h00);
    check("idle_rd_addr", rd_addr, 8'h00);
    rstn = 0;
    clk_en = 1;
    @(negedge sclk);
    rstn = 1;

    mem[8'h05] = 8'hA3;
    send_addr(8'h05);
    check("a05_rd_addr", rd_addr, 8'h05);
    check("a05_first_bit", {7'b0, poci}, 8'h01);
    read_byte(d, -1, 0, 0);
    check("a05_byte", d, 8'hA3);
    check("a05_next_addr", rd_addr, 8'h06);
    check("a05_byte_done", {7'b0, byte_done}, 8'h01);
    @(negedge sclk);
    check("a05_byte_done_low", {7'b0, byte_done}, 8'h00);

    do_reset;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    send_addr(8'hFE);
    read_byte(d, -1, 0, 0);
    check("wrap_byte0", d, 8'h11);
    read_byte(d, -1, 0, 0);
    check("wrap_byte1", d, 8'h22);
    check("wrap_addr00", rd_addr, 8'h00);
    read_byte(d, -1, 0, 0);
    check("wrap_byte2", d, 8'h33);
    check("wrap_addr01", rd_addr, 8'h01);

    do_reset;
    mem[8'h40] = 8'h0F; mem[8'h41] = 8'h5A;
    send_addr(8'h40);
    read_byte(d, 3, 8'h40, 8'hF0);
    check("midchg_byte", d, 8'h0F);
    read_byte(d, -1, 0, 0);
    check("midchg_next", d, 8'h5A);

    do_reset;
    mem[8'h22] = 8'hFF; mem[8'h10] = 8'hC6;
    send_addr(8'h22);
    repeat (4) @(negedge sclk);
    rstn = 0;
    #1;
    check("abort_poci", {7'b0, poci}, 8'h00);
    check("abort_oe", {7'b0, poci_oe}, 8'h00);
    check("abort_rd_addr", rd_addr, 8'h00);
    @(negedge sclk);
    rstn = 1;
    send_addr(8'h10);
    check("abort_new_addr", rd_addr, 8'h10);
    read_byte(d, -1, 0, 0);
    check("abort_new_byte", d, 8'hC6);

    repeat (30) begin
      do_reset;
      a = 8'($urandom);
      send_addr(a);
      for (int j = 0; j < int'($urandom_range(1, 4)); j++)
        read_byte(d, int'($urandom_range(0, 9)), a + 8'(j), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/poci_tx.md
# poci_tx

Peripheral-out/controller-in transmitter for the SPI-style configuration port. It decodes the address byte arriving on serial_in and drives the selected register's contents back to the controller on poci, MSB first. The read address auto-increments for every following byte until the frame is reset. It sits beside the controller-to-peripheral receive path, shares sclk and the combined external/sclk-stop reset, and drives the register read mux through rd_addr.

## Interface
Parameters:
- DATA_W, 8, width of a serial byte, of rd_data and of rd_addr

Ports:
- sclk  input  1  SPI clock; the only clock; all state updates on posedge
- rstn  input  1  reset, asynchronous, active-low; the parent ANDs the external reset with the sclk-stop reset
- serial_in  input  1  controller-to-peripheral serial data, MSB first
- rd_data  input  DATA_W  combinational read-mux output for rd_addr
- rd_addr  output  DATA_W  read address driven to the register mux
- poci  output  1  serial read data to the controller
- poci_oe  output  1  high while a data byte is being driven
- byte_done  output  1  one-cycle pulse after the last bit of each data byte

## Operation
- Two states, ADDR and DATA, plus bit_cnt[2:0], the bit index within the current byte.
- ADDR:
  - Shift serial_in into addr_sr on each posedge.
  - poci=0, poci_oe=0.
  - On the posedge where bit_cnt==7: rd_addr <= {addr_sr[6:0], serial_in}, bit_cnt wraps to 0, state goes to DATA.
  - Address 0x00 is legal.
- DATA:
  - While bit_cnt==0: poci = rd_data[DATA_W-1], driven combinationally so the MSB is valid without waiting a cycle.
  - On the posedge ending bit 0: tx_sr <= {rd_data[DATA_W-2:0], 1'b0}.
  - For bit_cnt 1..7: poci = tx_sr[DATA_W-1]; tx_sr shifts left once per posedge.
  - On the posedge ending bit 7: rd_addr <= rd_addr+1, with 0xFF wrapping to 0x00. byte_done is registered high for the next cycle. bit_cnt wraps and the state stays DATA.
  - serial_in is ignored in DATA, including write data sent at the same time.
- rd_data is sampled exactly once per byte, at the end of bit 0. Later changes to the register, such as a write to the same address, do not affect the byte in flight.
- Reset values: state=ADDR, bit_cnt=0, addr_sr=0, tx_sr=0, rd_addr=0x00, poci=0, poci_oe=0, byte_done=0.
- Reset mid-byte (rstn low, including the sclk-stop reset) aborts immediately. The next sclk edge after release starts a new address byte.

## Timing
- Sampling convention: poci changes just after a posedge; the controller samples it on the following posedge.
- Frame bits are numbered 1..n, bit k ending at posedge k.
  - Posedge 8: rd_addr=A. The bit-9 window shows rd_data(A)[7], sampled at posedge 9.
  - Posedges 9..16: the controller samples D(A)[7..0].
  - After posedge 16: rd_addr=A+1, byte_done=1 for one cycle, and poci shows D(A+1)[7].
- Latency from address LSB to first data bit: zero dead cycles.
- The rd_addr to rd_data path must settle within one sclk period, in the same cycle.
- poci_oe rises after posedge 8. It stays high until reset.

## Structure
- Shared package pico_pkg:
  - typedef enum logic {ADDR, DATA} poci_state_t
  - localparam BYTE_W = 8
  - localparam BIT_CNT_W = 3
  - The receive path reuses BYTE_W.
- One sub-module, piso_shift_register (parallel load, shift left, serial MSB out, async active-low reset). It is the counterpart of the receive-side serial-to-parallel register and holds tx_sr.
- The FSM, bit counter, address register and byte_done live in poci_tx.

## Test plan
- Reset → all outputs at reset values; rstn deasserted with sclk idle → poci=0, poci_oe=0, rd_addr=0x00.
- Address 0x05 with reg[5]=0xA3 → rd_addr=0x05 after posedge 8; poci bits 9..16 = 1,0,1,0,0,0,1,1; byte_done pulses after posedge 16; rd_addr=0x06.
- Address 0xFE, three data bytes with reg[FE]=0x11, reg[FF]=0x22, reg[00]=0x33 → bytes read back 0x11, 0x22, 0x33; rd_addr wraps to 0x00, then 0x01.
- rd_data for the current address changes from 0x0F to 0xF0 during bit 3 → the byte still reads 0x0F; the next byte reads the new address.
- rstn pulsed low after bit 4 of a data byte → poci=0 and state=ADDR immediately; new address 0x10 is decoded correctly, with reg[0x10] as the first data byte.
